// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART TX types, frame constants and the baud divisor
//               helper. UART_TX_PARITY_EN adds the PARITY state.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;
`endif

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Single-clock FIFO with occupancy count, async active-low reset.
// Revision    : 1.0  initial release
// ============================================================================
module uart_byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_count == (c_AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_wr      = i_wr_en && !o_full;
   assign w_rd      = i_rd_en && !o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_ctrl
// Description : FIFO-buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an
//               even parity bit (8E1).
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 200000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk_200MHz,
   input  logic                          rst,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int c_CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
   localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
   localparam logic [2:0] c_DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] c_STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_t          r_state, w_state_nxt;
   logic [c_CNT_W-1:0] r_baud, w_baud_nxt;
   logic [2:0]         r_bit_idx, w_bit_idx_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic               r_txd, w_txd_nxt;
   logic               w_bit_done;
   logic               w_pop;
   logic               w_push;
   logic [7:0]         w_fifo_head;
   logic               w_fifo_empty;
   logic               w_fifo_full;
`ifdef UART_TX_PARITY_EN
   logic               r_parity, w_parity_nxt;
`endif

   assign in_ready   = !w_fifo_full;
   assign w_push     = in_valid && in_ready;
   assign w_bit_done = (r_baud == c_BAUD_LAST);
   assign txd        = r_txd;
   assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk_200MHz),
      .rst       (rst),
      .i_wr_en   (w_push),
      .i_wr_data (in_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_fifo_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_count   (fifo_count)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud + 1'b1;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt  = r_parity;
`endif
      case (r_state)
         ST_IDLE: begin
            w_baud_nxt = '0;
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_head;
`ifdef UART_TX_PARITY_EN
               w_parity_nxt = ^w_fifo_head;
`endif
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_done) begin
               w_baud_nxt    = '0;
               w_bit_idx_nxt = '0;
               w_state_nxt   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_bit_done) begin
               w_baud_nxt  = '0;
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_idx == c_DATA_LAST) begin
                  w_bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt   = ST_PARITY;
`else
                  w_state_nxt   = ST_STOP;
`endif
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_done) begin
               w_baud_nxt  = '0;
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_done) begin
               w_baud_nxt = '0;
               if (r_bit_idx == c_STOP_LAST) begin
                  w_bit_idx_nxt = '0;
                  // Chain straight into the next frame with no idle gap.
                  if (!w_fifo_empty) begin
                     w_pop       = 1'b1;
                     w_shift_nxt = w_fifo_head;
`ifdef UART_TX_PARITY_EN
                     w_parity_nxt = ^w_fifo_head;
`endif
                     w_state_nxt = ST_START;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
         default: begin
            w_baud_nxt  = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase

      // txd is derived from the next state so the registered line moves on
      // the same edge as the state change.
      case (w_state_nxt)
         ST_START:  w_txd_nxt = 1'b0;
         ST_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_txd_nxt = w_parity_nxt;
`endif
         default:   w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk_200MHz or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_txd     <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_ctrl
// Description : Self-checking bench: vector table, corner sequences and random
//               traffic against a queue-and-frame-timer reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo_ctrl;

   localparam int CLK_FREQ   = 1000;
   localparam int BAUD_RATE  = 100;
   localparam int FIFO_DEPTH = 8;
   localparam int C          = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME      = 11 * C;
`else
   localparam int FRAME      = 10 * C;
`endif

   logic       clk_200MHz = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       txd;
   logic       busy;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of pending bytes plus a frame timer.
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_t      = 0;
   logic [7:0] m_cur    = 8'h00;
   bit         m_acc    = 1'b0;

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         ready;
      int         count;
      bit         busy;
      bit         txd;
   } vec_t;
   vec_t tbl[5];

   uart_tx_fifo_ctrl #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_200MHz (clk_200MHz),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .txd        (txd),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk_200MHz = ~clk_200MHz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic bit exp_txd();
      if (!m_active) return 1'b1;
      return frame_bit(m_cur, m_t / C);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
   endtask

   // Advance the model over one edge using pre-edge inputs, then compare.
   task automatic tick();
      bit acc;
      acc = in_valid && (m_q.size() != FIFO_DEPTH);
      if (m_active) begin
         m_t++;
         if (m_t == FRAME) m_active = 1'b0;
      end
      if (!m_active && m_q.size() != 0) begin
         m_cur    = m_q.pop_front();
         m_active = 1'b1;
         m_t      = 0;
      end
      if (acc) m_q.push_back(in_data);
      m_acc = acc;
      @(posedge clk_200MHz);
      #1;
      chk("txd", txd, exp_txd());
      chk("in_ready", in_ready, (m_q.size() != FIFO_DEPTH));
      chk("busy", busy, (m_active || m_q.size() != 0));
      chk("fifo_count", fifo_count, m_q.size());
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      in_valid = 1'b0;
      while ((m_active || m_q.size() != 0) && guard < 3000) begin
         tick();
         guard++;
      end
      chk({name, "_idle_busy"}, busy, 0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int guard;
      int sent;
      bit seen_full;
      int pct;

      tbl[0] = '{v:1'b1, d:8'h41, ready:1'b1, count:1, busy:1'b1, txd:1'b1};
      tbl[1] = '{v:1'b0, d:8'hFF, ready:1'b1, count:0, busy:1'b1, txd:1'b0};
      tbl[2] = '{v:1'b1, d:8'h48, ready:1'b1, count:1, busy:1'b1, txd:1'b0};
      tbl[3] = '{v:1'b1, d:8'h69, ready:1'b1, count:2, busy:1'b1, txd:1'b0};
      tbl[4] = '{v:1'b0, d:8'h00, ready:1'b1, count:2, busy:1'b1, txd:1'b0};

      in_valid = 1'b0;
      in_data  = 8'h00;
      rst      = 1'b0;
      repeat (3) @(negedge clk_200MHz);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", in_ready, 1);
      rst = 1'b1;
      model_reset();

      // Single byte followed by a back-to-back pair.
      for (int i = 0; i < 5; i++) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         tick();
         chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].ready);
         chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].count);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("tbl%0d_txd", i), txd, tbl[i].txd);
      end
      wait_idle("tbl");

      // Ten bytes with in_valid held high: ready must drop at full.
      sent = 0;
      guard = 0;
      seen_full = 1'b0;
      in_valid = 1'b1;
      while (sent < 10 && guard < 3000) begin
         in_data = 8'h10 + 8'(sent);
         tick();
         if (m_acc) sent++;
         if (!seen_full && m_q.size() == FIFO_DEPTH) begin
            seen_full = 1'b1;
            chk("full_ready", in_ready, 0);
            chk("full_count", fifo_count, FIFO_DEPTH);
         end
         guard++;
      end
      in_valid = 1'b0;
      chk("full_sent", sent, 10);
      chk("full_seen", seen_full, 1);

      // Push on the STOP->START pop edge with three bytes queued.
      guard = 0;
      while (!(m_q.size() == 3 && m_active && m_t == FRAME - 1) && guard < 3000) begin
         tick();
         guard++;
      end
      chk("pushpop_reached", (guard < 3000), 1);
      push_byte(8'hC3);
      chk("pushpop_count", fifo_count, 3);
      wait_idle("pushpop");

      // Asynchronous reset during data bit 4 of 0x55, with a byte queued.
      push_byte(8'h55);
      push_byte(8'hAA);
      guard = 0;
      while (!(m_active && m_t == 5 * C + 3) && guard < 500) begin
         tick();
         guard++;
      end
      chk("rst_mid_reached", (guard < 500), 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_txd", txd, 1);
      chk("rst_mid_count", fifo_count, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", in_ready, 1);
      model_reset();
      @(negedge clk_200MHz);
      @(negedge clk_200MHz);
      rst = 1'b1;
      push_byte(8'h0A);
      push_byte(8'h4F);
      push_byte(8'h4B);
      wait_idle("post_rst");

      // Random traffic alternating light and bursty phases.
      for (int i = 0; i < 4000; i++) begin
         pct = ((i / 400) % 2) ? 70 : 8;
         in_valid = ($urandom_range(0, 99) < pct);
         in_data  = 8'($urandom);
         tick();
      end
      wait_idle("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
